// File: rtl/tempo_pkg.sv
// ============================================================================
//  Package     : tempo_pkg
//  Description : Shared tempo defaults and width/threshold helpers for the
//                tempo step scheduler.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package tempo_pkg;

    typedef longint unsigned u64_t;

    localparam int unsigned BPM_MIN_DEF   = 40;
    localparam int unsigned BPM_MAX_DEF   = 240;
    localparam int unsigned BPM_INC_DEF   = 5;
    localparam int unsigned BPM_RESET_DEF = 120;
    localparam int unsigned STEPS_DEF     = 8;

    // One step is due each time the accumulator gains CLK_HZ*60.
    function automatic u64_t thresh_of(input u64_t clk_hz);
        return clk_hz * 64'd60;
    endfunction

    function automatic int acc_width(input u64_t clk_hz, input int unsigned bpm_max,
                                     input int unsigned tpb);
        return $clog2(thresh_of(clk_hz) + u64_t'(bpm_max) * u64_t'(tpb));
    endfunction

    function automatic int step_width(input int unsigned steps);
        return $clog2(steps);
    endfunction

    localparam int STEP_W_DEF = step_width(STEPS_DEF);

endpackage

`default_nettype wire

// File: rtl/bpm_register.sv
// ============================================================================
//  Module      : bpm_register
//  Description : Saturating tempo register with a one-cycle change pulse.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module bpm_register
    import tempo_pkg::*;
#(
    parameter int unsigned BPM_MIN   = BPM_MIN_DEF,
    parameter int unsigned BPM_MAX   = BPM_MAX_DEF,
    parameter int unsigned BPM_INC   = BPM_INC_DEF,
    parameter int unsigned BPM_RESET = BPM_RESET_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [7:0] bpm_o,
    output logic       changed_o
);

    logic [7:0] bpm_q, bpm_d;
    logic       changed_q, changed_d;
    logic [8:0] sum_w;
    logic [7:0] up_w, dn_w;

    always_comb begin
        sum_w = {1'b0, bpm_q} + 9'(BPM_INC);
        up_w  = (sum_w > 9'(BPM_MAX)) ? 8'(BPM_MAX) : sum_w[7:0];
        // Guarded subtract: never goes below BPM_MIN, so no wrap.
        dn_w  = ({1'b0, bpm_q} < 9'(BPM_MIN + BPM_INC)) ? 8'(BPM_MIN)
                                                        : bpm_q - 8'(BPM_INC);
        bpm_d = bpm_q;
        case ({inc_i, dec_i})
            2'b10:   bpm_d = up_w;
            2'b01:   bpm_d = dn_w;
            default: bpm_d = bpm_q;
        endcase
        changed_d = (bpm_d != bpm_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bpm_q     <= 8'(BPM_RESET);
            changed_q <= 1'b0;
        end else begin
            bpm_q     <= bpm_d;
            changed_q <= changed_d;
        end
    end

    assign bpm_o     = bpm_q;
    assign changed_o = changed_q;

endmodule

`default_nettype wire

// File: rtl/tempo_step_scheduler.sv
// ============================================================================
//  Module      : tempo_step_scheduler
//  Description : Phase-accumulator step clock with run control, wrapping step
//                index, beat marker and button-adjustable tempo.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tempo_step_scheduler
    import tempo_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned STEPS          = STEPS_DEF,
    parameter int unsigned TICKS_PER_BEAT = 4,
    parameter int unsigned BPM_MIN        = BPM_MIN_DEF,
    parameter int unsigned BPM_MAX        = BPM_MAX_DEF,
    parameter int unsigned BPM_INC        = BPM_INC_DEF,
    parameter int unsigned BPM_RESET      = BPM_RESET_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           btn_inc_bpm,
    input  logic                           btn_dec_bpm,
    input  logic                           run_toggle,
    output logic [7:0]                     bpm,
    output logic                           running,
    output logic                           step_tick,
    output logic                           beat_tick,
    output logic [step_width(STEPS)-1:0]   step_idx,
    output logic                           bpm_changed
);

    localparam u64_t THRESH = thresh_of(u64_t'(CLK_HZ));
    localparam int   ACC_W  = acc_width(u64_t'(CLK_HZ), BPM_MAX, TICKS_PER_BEAT);
    localparam int   STEP_W = step_width(STEPS);
    localparam logic [ACC_W-1:0]  THRESH_C  = ACC_W'(THRESH);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    logic [7:0]        bpm_w;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  inc_w, sum_w;
    logic [STEP_W-1:0] step_idx_q, step_idx_d, idx_next_w;
    logic              running_q, running_d;
    logic              step_tick_q, step_tick_d;
    logic              beat_tick_q, beat_tick_d;
    logic              fire_w, beat_w;

    bpm_register #(
        .BPM_MIN   (BPM_MIN),
        .BPM_MAX   (BPM_MAX),
        .BPM_INC   (BPM_INC),
        .BPM_RESET (BPM_RESET)
    ) u_bpm (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (btn_inc_bpm),
        .dec_i     (btn_dec_bpm),
        .bpm_o     (bpm_w),
        .changed_o (bpm_changed)
    );

    always_comb begin
        inc_w      = ACC_W'(bpm_w) * ACC_W'(TICKS_PER_BEAT);
        sum_w      = acc_q + inc_w;
        fire_w     = running_q && (sum_w >= THRESH_C);
        idx_next_w = (step_idx_q == LAST_STEP) ? '0 : step_idx_q + 1'b1;
        beat_w     = ((32'(idx_next_w) % TICKS_PER_BEAT) == 32'd0);

        acc_d       = acc_q;
        step_idx_d  = step_idx_q;
        running_d   = running_q ^ run_toggle;
        step_tick_d = fire_w;
        beat_tick_d = fire_w && beat_w;
        // Remainder is carried over so the long-run rate is exact.
        if (running_q)
            acc_d = fire_w ? (sum_w - THRESH_C) : sum_w;
        if (fire_w)
            step_idx_d = idx_next_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            step_idx_q  <= '0;
            running_q   <= 1'b1;
            step_tick_q <= 1'b0;
            beat_tick_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            step_idx_q  <= step_idx_d;
            running_q   <= running_d;
            step_tick_q <= step_tick_d;
            beat_tick_q <= beat_tick_d;
        end
    end

    assign bpm       = bpm_w;
    assign running   = running_q;
    assign step_tick = step_tick_q;
    assign beat_tick = beat_tick_q;
    assign step_idx  = step_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_tempo_step_scheduler.sv
// ============================================================================
//  Module      : tb_tempo_step_scheduler
//  Description : Self-checking bench for tempo_step_scheduler at CLK_HZ=1000.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_tempo_step_scheduler;

    localparam int     TPB    = 4;
    localparam int     STEPS  = 8;
    localparam longint THRESH = 64'd60000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_inc_bpm = 1'b0;
    logic       btn_dec_bpm = 1'b0;
    logic       run_toggle  = 1'b0;
    logic [7:0] bpm;
    logic       running, step_tick, beat_tick, bpm_changed;
    logic [2:0] step_idx;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    int     m_bpm  = 120;
    bit     m_run  = 1'b1;
    longint m_acc  = 0;
    int     m_idx  = 0;
    bit     m_step = 1'b0;
    bit     m_beat = 1'b0;
    bit     m_chg  = 1'b0;

    tempo_step_scheduler #(.CLK_HZ(1000)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_inc_bpm (btn_inc_bpm),
        .btn_dec_bpm (btn_dec_bpm),
        .run_toggle  (run_toggle),
        .bpm         (bpm),
        .running     (running),
        .step_tick   (step_tick),
        .beat_tick   (beat_tick),
        .step_idx    (step_idx),
        .bpm_changed (bpm_changed)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit inc, input bit dec, input bit tog, input bit r);
        bit fire;
        int nb;
        if (r) begin
            m_bpm = 120; m_run = 1'b1; m_acc = 0; m_idx = 0;
            m_step = 1'b0; m_beat = 1'b0; m_chg = 1'b0;
        end else begin
            fire = m_run && (m_acc + m_bpm * TPB >= THRESH);
            nb = m_bpm;
            if (inc && !dec) nb = (m_bpm + 5 > 240) ? 240 : m_bpm + 5;
            if (dec && !inc) nb = (m_bpm - 5 < 40) ? 40 : m_bpm - 5;
            if (m_run) m_acc = m_acc + m_bpm * TPB - (fire ? THRESH : 0);
            if (fire) m_idx = (m_idx + 1) % STEPS;
            m_step = fire;
            m_beat = fire && (m_idx % TPB == 0);
            m_chg  = (nb != m_bpm);
            m_bpm  = nb;
            if (tog) m_run = !m_run;
        end
    endtask

    task automatic cyc(input bit inc, input bit dec, input bit tog, input bit r);
        btn_inc_bpm = inc;
        btn_dec_bpm = dec;
        run_toggle  = tog;
        rst         = r;
        @(posedge clk);
        model_step(inc, dec, tog, r);
        #1;
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 1, 1);
        n_total++; if (bpm !== 8'd120) $display("FAIL reset_bpm: got %0d expected 120", bpm); else n_pass++;
        n_total++; if (running !== 1'b1) $display("FAIL reset_running: got %0b expected 1", running); else n_pass++;
        n_total++; if (step_idx !== 3'd0) $display("FAIL reset_idx: got %0d expected 0", step_idx); else n_pass++;
        n_total++; if (step_tick !== 1'b0) $display("FAIL reset_step_tick: got %0b expected 0", step_tick); else n_pass++;
        n_total++; if (beat_tick !== 1'b0) $display("FAIL reset_beat_tick: got %0b expected 0", beat_tick); else n_pass++;
        n_total++; if (bpm_changed !== 1'b0) $display("FAIL reset_bpm_changed: got %0b expected 0", bpm_changed); else n_pass++;
    endtask

    task automatic test_period();
        int exp_idx[8]  = '{1, 2, 3, 4, 5, 6, 7, 0};
        bit exp_beat[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int t = 0, last = 0, k = 0;
        while (k < 8 && t < 1200) begin
            cyc(0, 0, 0, 0);
            t++;
            if (step_tick) begin
                n_total++; if (t - last != 125) $display("FAIL period_120: got %0d expected 125", t - last); else n_pass++;
                n_total++; if (step_idx !== 3'(exp_idx[k])) $display("FAIL period_idx: got %0d expected %0d", step_idx, exp_idx[k]); else n_pass++;
                n_total++; if (beat_tick !== exp_beat[k]) $display("FAIL period_beat: got %0b expected %0b", beat_tick, exp_beat[k]); else n_pass++;
                last = t;
                k++;
            end else if (beat_tick) begin
                n_total++; $display("FAIL beat_without_step: got 1 expected 0");
            end
        end
        n_total++; if (k != 8) $display("FAIL period_timeout: got %0d ticks expected 8", k); else n_pass++;
    endtask

    task automatic test_inc_tempo();
        int t, total;
        cyc(1, 0, 0, 0);
        n_total++; if (bpm !== 8'd125) $display("FAIL inc1_bpm: got %0d expected 125", bpm); else n_pass++;
        n_total++; if (bpm_changed !== 1'b1) $display("FAIL inc1_changed: got %0b expected 1", bpm_changed); else n_pass++;
        cyc(0, 0, 0, 0);
        n_total++; if (bpm_changed !== 1'b0) $display("FAIL inc1_changed_clear: got %0b expected 0", bpm_changed); else n_pass++;
        t = 0;
        do begin cyc(0, 0, 0, 0); t++; end while (!step_tick && t < 200);
        t = 0;
        do begin cyc(0, 0, 0, 0); t++; end while (!step_tick && t < 200);
        n_total++; if (t != 120) $display("FAIL period_125: got %0d expected 120", t); else n_pass++;
        cyc(1, 0, 0, 0);
        n_total++; if (bpm !== 8'd130) $display("FAIL inc2_bpm: got %0d expected 130", bpm); else n_pass++;
        n_total++; if (bpm_changed !== 1'b1) $display("FAIL inc2_changed: got %0b expected 1", bpm_changed); else n_pass++;
        t = 0;
        do begin cyc(0, 0, 0, 0); t++; end while (!step_tick && t < 200);
        total = 0;
        for (int k = 0; k < 13; k++) begin
            t = 0;
            do begin cyc(0, 0, 0, 0); t++; end while (!step_tick && t < 200);
            n_total++; if (t != 115 && t != 116) $display("FAIL period_130: got %0d expected 115 or 116", t); else n_pass++;
            total += t;
        end
        n_total++; if (total != 1500) $display("FAIL span_130: got %0d expected 1500", total); else n_pass++;
    endtask

    task automatic test_saturation();
        int exp_bpm[5] = '{45, 40, 40, 40, 40};
        int chg = 0;
        repeat (16) begin cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); end
        n_total++; if (bpm !== 8'd50) $display("FAIL dec_to_50: got %0d expected 50", bpm); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0);
            if (bpm_changed) chg++;
            n_total++; if (bpm !== 8'(exp_bpm[i])) $display("FAIL dec_sat_bpm: got %0d expected %0d", bpm, exp_bpm[i]); else n_pass++;
            cyc(0, 0, 0, 0);
            if (bpm_changed) chg++;
        end
        n_total++; if (chg != 2) $display("FAIL dec_sat_changed: got %0d pulses expected 2", chg); else n_pass++;
        repeat (40) begin cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); end
        n_total++; if (bpm !== 8'd240) $display("FAIL inc_to_240: got %0d expected 240", bpm); else n_pass++;
        cyc(1, 0, 0, 0);
        n_total++; if (bpm !== 8'd240) $display("FAIL inc_sat_bpm: got %0d expected 240", bpm); else n_pass++;
        n_total++; if (bpm_changed !== 1'b0) $display("FAIL inc_sat_changed: got %0b expected 0", bpm_changed); else n_pass++;
        repeat (24) begin cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); end
        n_total++; if (bpm !== 8'd120) $display("FAIL dec_to_120: got %0d expected 120", bpm); else n_pass++;
        cyc(1, 1, 0, 0);
        n_total++; if (bpm !== 8'd120) $display("FAIL both_bpm: got %0d expected 120", bpm); else n_pass++;
        n_total++; if (bpm_changed !== 1'b0) $display("FAIL both_changed: got %0b expected 0", bpm_changed); else n_pass++;
    endtask

    task automatic test_run_toggle();
        int ticks = 0, t = 0;
        cyc(0, 0, 0, 1);
        repeat (59) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        n_total++; if (running !== 1'b0) $display("FAIL stop_running: got %0b expected 0", running); else n_pass++;
        repeat (1000) begin cyc(0, 0, 0, 0); if (step_tick) ticks++; end
        n_total++; if (ticks != 0) $display("FAIL stopped_ticks: got %0d expected 0", ticks); else n_pass++;
        n_total++; if (step_idx !== 3'd0) $display("FAIL stopped_idx: got %0d expected 0", step_idx); else n_pass++;
        cyc(0, 0, 1, 0);
        n_total++; if (running !== 1'b1) $display("FAIL resume_running: got %0b expected 1", running); else n_pass++;
        do begin cyc(0, 0, 0, 0); t++; end while (!step_tick && t < 200);
        n_total++; if (t != 65) $display("FAIL resume_latency: got %0d expected 65", t); else n_pass++;
        n_total++; if (step_idx !== 3'd1) $display("FAIL resume_idx: got %0d expected 1", step_idx); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t = 0;
        cyc(0, 0, 0, 1);
        repeat (6) begin cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); end
        n_total++; if (bpm !== 8'd150) $display("FAIL mid_bpm: got %0d expected 150", bpm); else n_pass++;
        while (step_idx !== 3'd5 && t < 2000) begin cyc(0, 0, 0, 0); t++; end
        n_total++; if (step_idx !== 3'd5) $display("FAIL mid_reach_5: got %0d expected 5", step_idx); else n_pass++;
        repeat (10) cyc(0, 0, 0, 1);
        n_total++; if (bpm !== 8'd120) $display("FAIL mid_rst_bpm: got %0d expected 120", bpm); else n_pass++;
        n_total++; if (step_idx !== 3'd0) $display("FAIL mid_rst_idx: got %0d expected 0", step_idx); else n_pass++;
        n_total++; if ({running, step_tick, beat_tick, bpm_changed} !== 4'b1000)
            $display("FAIL mid_rst_flags: got %b expected 1000", {running, step_tick, beat_tick, bpm_changed}); else n_pass++;
        t = 0;
        do begin cyc(0, 0, 0, 0); t++; end while (!step_tick && t < 300);
        n_total++; if (t != 125) $display("FAIL mid_first_tick: got %0d expected 125", t); else n_pass++;
        n_total++; if (step_idx !== 3'd1) $display("FAIL mid_first_idx: got %0d expected 1", step_idx); else n_pass++;
    endtask

    task automatic test_toggle_on_fire();
        int ticks = 0;
        cyc(0, 0, 0, 1);
        repeat (124) begin cyc(0, 0, 0, 0); if (step_tick) ticks++; end
        n_total++; if (ticks != 0) $display("FAIL prefire_ticks: got %0d expected 0", ticks); else n_pass++;
        cyc(0, 0, 1, 0);
        n_total++; if (step_tick !== 1'b1) $display("FAIL fire_toggle_tick: got %0b expected 1", step_tick); else n_pass++;
        n_total++; if (running !== 1'b0) $display("FAIL fire_toggle_running: got %0b expected 0", running); else n_pass++;
        n_total++; if (step_idx !== 3'd1) $display("FAIL fire_toggle_idx: got %0d expected 1", step_idx); else n_pass++;
        ticks = 0;
        repeat (300) begin cyc(0, 0, 0, 0); if (step_tick) ticks++; end
        n_total++; if (ticks != 0) $display("FAIL post_toggle_ticks: got %0d expected 0", ticks); else n_pass++;
    endtask

    task automatic test_random();
        bit inc, dec, tog, r;
        logic [14:0] got, exp;
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            inc = ($urandom % 16) == 0;
            dec = ($urandom % 16) == 0;
            tog = ($urandom % 150) == 0;
            r   = ($urandom % 1500) == 0;
            cyc(inc, dec, tog, r);
            got = {bpm, running, step_tick, beat_tick, step_idx, bpm_changed};
            exp = {8'(m_bpm), m_run, m_step, m_beat, 3'(m_idx), m_chg};
            n_total++;
            if (got !== exp) $display("FAIL random_cycle_%0d: got %h expected %h", i, got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_period();
        test_inc_tempo();
        test_saturation();
        test_run_toggle();
        test_reset_mid();
        test_toggle_on_fire();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tempo_step_scheduler.md
Name: tempo_step_scheduler

Overview:
Generates the step timing that drives the step sequencer. It holds the tempo in BPM, which the conditioned inc/dec button pulses adjust with saturation. It produces a one-cycle step tick at TICKS_PER_BEAT steps per beat, using a phase accumulator for exact average rate, plus a wrapping step index and beat marker. It sits between the button conditioners and the sequencer's step/LED/UART logic and also supplies the BPM value for the 7-segment display and UART reporting.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
STEPS, 8, number of steps in the pattern (>=2)
TICKS_PER_BEAT, 4, steps per beat (16th notes)
BPM_MIN, 40, lowest tempo
BPM_MAX, 240, highest tempo (<=255)
BPM_INC, 5, tempo change per button pulse
BPM_RESET, 120, tempo after reset

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
btn_inc_bpm  in  1  one-cycle pulse: raise tempo
btn_dec_bpm  in  1  one-cycle pulse: lower tempo
run_toggle  in  1  one-cycle pulse: toggle run/stop
bpm  out  8  current tempo, registered
running  out  1  1 = stepping enabled
step_tick  out  1  one-cycle pulse per step
beat_tick  out  1  one-cycle pulse coincident with step_tick on beat boundaries
step_idx  out  $clog2(STEPS)  current step, registered
bpm_changed  out  1  one-cycle pulse the cycle after bpm changes value

Behaviour:
- Reset values (rst high at an edge): bpm=BPM_RESET, running=1, acc=0, step_idx=0, step_tick=0, beat_tick=0, bpm_changed=0. Reset overrides all inputs in the same cycle.
- Tempo: inc pulse sets bpm=min(bpm+BPM_INC, BPM_MAX). Dec pulse sets bpm=max(bpm-BPM_INC, BPM_MIN). Compute in 9 bits, with no wrap. inc and dec in the same cycle: no change. A pulse at a limit: no change and no bpm_changed.
- bpm_changed: asserted for 1 cycle the cycle after bpm takes a new value.
- Run control: run_toggle flips running, effective next cycle. While stopped, acc, step_idx and bpm stay adjustable/held, and no ticks are produced. On resume, timing continues from the held acc, with no immediate tick.
- Phase accumulator:
  - THRESH = CLK_HZ*60.
  - INC = bpm*TICKS_PER_BEAT.
  - ACC_W = $clog2(THRESH + BPM_MAX*TICKS_PER_BEAT) bits (33 at defaults).
  - Each running cycle: if acc+INC >= THRESH, then acc <= acc+INC-THRESH and a tick fires; else acc <= acc+INC.
  - INC uses the bpm register value of the current cycle. A tempo change does not clear acc, so phase is continuous.
- Tick: on a firing cycle, the next edge sets step_tick=1 for exactly 1 cycle. In the same edge, step_idx advances, wrapping STEPS-1 -> 0. step_idx therefore already shows the new step while step_tick is high.
- beat_tick=1 with step_tick when the new step_idx mod TICKS_PER_BEAT == 0.
- Tick latency: 1 cycle from the threshold crossing to step_tick.
- Average step period: THRESH/INC clocks. Individual periods differ by at most 1 clock.
- run_toggle arriving in a firing cycle: that tick is still issued, then running clears.
- Reset mid-operation: all state returns to its reset values. The first tick after reset comes after ceil(THRESH/INC) clocks.

Decomposition:
- Shared package tempo_pkg: THRESH/ACC_W computation function, BPM_MIN/MAX/INC/RESET defaults, and STEP_W = $clog2(STEPS).
- One sub-module, bpm_register: saturating up/down 8-bit register with inc/dec/simultaneous rules and the bpm_changed pulse.
- The accumulator, run flag and step counter stay in the top of the block.

Test Plan:
- CLK_HZ=1000, defaults; release reset -> step_tick every 125 clocks exactly; step_idx 0->1 on first tick (125 clocks after reset) … 7->0 on the 8th; beat_tick on steps 4 and 0.
- Two inc pulses -> bpm 120->125->130, bpm_changed each once; at 125, period = 120 clocks; at 130, 60000/520, so periods are 115/116 averaging 115.38 over 13 ticks (exactly 1500 clocks).
- Dec pulses from 50 ×5 -> bpm 45, 40, 40, 40, 40; bpm_changed only twice. Inc to 240 then again -> stays 240. Simultaneous inc+dec at 120 -> 120, no bpm_changed.
- run_toggle at clock 60 after reset -> no ticks for 1000 clocks; toggle again -> first tick 65 clocks after resume, with step_idx continuing from the held value.
- rst asserted 10 clocks mid-pattern at step_idx=5, bpm=150 -> outputs return to reset values; first tick 125 clocks after rst drops; step_idx=1.
- run_toggle coincident with a firing cycle -> that step_tick still appears once, then running=0 and no further ticks.
